// File: rtl/alu_pkg.sv
// Shared encodings and types for the ALU and its round-robin arbiter.
// Holds no logic, so it adds no latency and has no backpressure of its own.
// Every user imports the whole package.
package alu_pkg;

    localparam logic [1:0] BOOL_XOR  = 2'b00;
    localparam logic [1:0] BOOL_ZERO = 2'b01;
    localparam logic [1:0] BOOL_OR   = 2'b10;
    localparam logic [1:0] BOOL_AND  = 2'b11;

    localparam int SEL_ADD  = 0;
    localparam int SEL_BOOL = 2;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } arb_state_t;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic        sub;
        logic [1:0]  bool_op;
        logic [2:0]  op_sel;
    } alu_req_t;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU: add/sub and boolean results, ORed by op_sel.
// Zero latency; no flow control, because the caller owns all sequencing.
// Add/sub wraps modulo 2^32. op_sel = 000 produces 0.
module alu
    import alu_pkg::*;
(
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic        sub,
    input  logic [1:0]  bool_op,
    input  logic [2:0]  op_sel,
    output logic [31:0] result
);

    logic [31:0] sum;
    logic [31:0] bool_res;
    logic        unused_sel;

    assign sum = sub ? (op_a - op_b) : (op_a + op_b);

    always_comb begin
        bool_res = '0;
        case (bool_op)
            BOOL_XOR:  bool_res = op_a ^ op_b;
            BOOL_ZERO: bool_res = '0;
            BOOL_OR:   bool_res = op_a | op_b;
            BOOL_AND:  bool_res = op_a & op_b;
        endcase
    end

    assign result = (op_sel[SEL_ADD]  ? sum      : 32'd0)
                  | (op_sel[SEL_BOOL] ? bool_res : 32'd0);

    // Bit 1 of op_sel has no function assigned to it.
    assign unused_sel = op_sel[1];

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one ALU among NUM_REQ requesters, with a registered result.
// Latency: a request accepted at edge N gives a valid response from edge N+1.
// Backpressure: an unconsumed response blocks new grants; if the response is consumed in the same cycle, a new request can issue back-to-back.
module alu_arbiter #(
    parameter int NUM_REQ = 2
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    output logic [NUM_REQ-1:0]    o_req_ready,
    input  logic [NUM_REQ*32-1:0] i_req_op_a,
    input  logic [NUM_REQ*32-1:0] i_req_op_b,
    input  logic [NUM_REQ-1:0]    i_req_sub,
    input  logic [NUM_REQ*2-1:0]  i_req_bool_op,
    input  logic [NUM_REQ*3-1:0]  i_req_op_sel,
    output logic [NUM_REQ-1:0]    o_rsp_valid,
    input  logic [NUM_REQ-1:0]    i_rsp_ready,
    output logic [31:0]           o_rsp_result
);
    import alu_pkg::*;

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_t       state_q;
    logic [IDX_W-1:0] owner_q;
    logic [IDX_W-1:0] rr_q;
    logic [31:0]      result_q;

    logic [IDX_W-1:0] win_idx;
    logic             win_vld;
    logic             rsp_hs;
    logic             issue_open;
    logic             accept;
    logic [31:0]      alu_result;
    alu_req_t         req_arr [NUM_REQ];
    alu_req_t         alu_in;

    // Search starts just after the last grant, so the most recent winner is tried last.
    function automatic logic [IDX_W:0] rr_pick(input logic [NUM_REQ-1:0] vld,
                                               input logic [IDX_W-1:0]   last);
        logic [IDX_W:0]   pick;
        logic [IDX_W-1:0] cand;
        pick = '0;
        for (int i = NUM_REQ; i >= 1; i--) begin
            cand = IDX_W'((int'(last) + i) % NUM_REQ);
            if (vld[cand]) pick = {1'b1, cand};
        end
        return pick;
    endfunction

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
        assign req_arr[k] = {i_req_op_a[32*k +: 32], i_req_op_b[32*k +: 32], i_req_sub[k],
                             i_req_bool_op[2*k +: 2], i_req_op_sel[3*k +: 3]};
    end

    assign {win_vld, win_idx} = rr_pick(i_req_valid, rr_q);

    assign rsp_hs     = (state_q == HOLD) && i_rsp_ready[owner_q];
    assign issue_open = (state_q == IDLE) || rsp_hs;
    assign accept     = win_vld && issue_open && !i_rst;

    assign alu_in = win_vld ? req_arr[win_idx] : '0;

    alu u_alu (
        .op_a    (alu_in.op_a),
        .op_b    (alu_in.op_b),
        .sub     (alu_in.sub),
        .bool_op (alu_in.bool_op),
        .op_sel  (alu_in.op_sel),
        .result  (alu_result)
    );

    always_comb begin
        o_req_ready = '0;
        if (accept) o_req_ready[win_idx] = 1'b1;
    end

    always_comb begin
        o_rsp_valid = '0;
        if ((state_q == HOLD) && !i_rst) o_rsp_valid[owner_q] = 1'b1;
    end

    assign o_rsp_result = result_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= IDLE;
            owner_q  <= '0;
            rr_q     <= IDX_W'(NUM_REQ - 1);
            result_q <= '0;
        end else if (accept) begin
            state_q  <= HOLD;
            owner_q  <= win_idx;
            rr_q     <= win_idx;
            result_q <= alu_result;
        end else if (rsp_hs) begin
            state_q  <= IDLE;
        end
    end

endmodule
